// File: rtl/adc_serial_avg.sv
// rtl/adc_serial_avg.sv - multi-channel serial ADC front end with per-channel moving average
//
// Drives chip-select and serial clock for an external SPI-style converter,
// deserialises each frame MSB first after discarding LEAD_BITS leading bits,
// tags the result with a round-robin channel index and keeps a moving average
// of the last 2^AVG_LOG2 samples of each channel.
//
// Build option: define ADC_AVG_EN to build the history/sum storage. Without it
// mean simply follows sample and mean_full is held at 1 on every mean_valid.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   run enable, sampled at frame boundaries
//   sdata        in   converter serial data
//   cs_n         out  converter chip select (active low)
//   sclk         out  serial clock, idles high
//   ch           out  channel for the current/next frame (external mux select)
//   sample       out  last raw conversion
//   sample_ch    out  channel of sample
//   sample_valid out  one-cycle strobe when sample updates
//   mean         out  moving average of sample_ch
//   mean_full    out  averaging window of sample_ch is full
//   mean_valid   out  one-cycle strobe when mean updates
module adc_serial_avg #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 4,
  parameter int DIV       = 1,
  parameter int QUIET     = 2,
  parameter int NCH       = 2,
  parameter int AVG_LOG2  = 3,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic [CH_W-1:0]   ch,
  output logic [DATA_W-1:0] sample,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic [DATA_W-1:0] mean,
  output logic              mean_full,
  output logic              mean_valid
);

  localparam int SHIFT_LEN = 2 * DIV * (LEAD_BITS + DATA_W);
  localparam int MAXC = (SHIFT_LEN > QUIET) ? ((SHIFT_LEN > DIV) ? SHIFT_LEN : DIV)
                                            : ((QUIET > DIV) ? QUIET : DIV);
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int PH_W  = $clog2(2 * DIV + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_AVG   = 3'd4;
  localparam logic [2:0] S_QUIET = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   ph_q, ph_d;     // position inside one sclk period
  logic              sclk_q, sclk_d;
  logic              cs_n_q;
  logic              cap;
  logic [DATA_W-1:0] shreg_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] sample_q;
  logic [CH_W-1:0]   sample_ch_q;
  logic              sample_valid_q;
  logic [DATA_W-1:0] mean_q;
  logic              mean_full_q;
  logic              mean_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          ph_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ph_d  = (ph_q == PH_W'(2 * DIV - 1)) ? '0 : ph_q + PH_W'(1);
        end
      end
      S_DONE:  state_d = S_AVG;
      S_AVG: begin
        state_d = S_QUIET;
        cnt_d   = '0;
      end
      S_QUIET: begin
        if (cnt_q == CNT_W'(QUIET - 1)) begin
          state_d = en ? S_START : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Low half of each bit first, then high half; sdata is taken on the edge
  // that raises sclk, so the converter has had the whole low half to settle.
  assign sclk_d = (state_d != S_SHIFT) || (ph_d >= PH_W'(DIV));
  assign cap    = (state_q == S_SHIFT) && (state_d == S_SHIFT) && (ph_d == PH_W'(DIV));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      ph_q           <= '0;
      sclk_q         <= 1'b1;
      cs_n_q         <= 1'b1;
      shreg_q        <= '0;
      ch_q           <= '0;
      sample_q       <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ph_q           <= ph_d;
      sclk_q         <= sclk_d;
      cs_n_q         <= !((state_d == S_START) || (state_d == S_SHIFT));
      sample_valid_q <= (state_q == S_SHIFT) && (state_d == S_DONE);
      // The shift register is DATA_W wide, so the lead bits fall off the top.
      if (cap) begin
        shreg_q <= {shreg_q[DATA_W-2:0], sdata};
      end
      if ((state_q == S_SHIFT) && (state_d == S_DONE)) begin
        sample_q    <= shreg_q;
        sample_ch_q <= ch_q;
      end
      // Advance the mux on entry to QUIET so it settles before the next frame.
      if (state_q == S_AVG) begin
        ch_q <= (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + CH_W'(1);
      end
    end
  end

`ifdef ADC_AVG_EN
  localparam int WIN   = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int NSLOT = 1 << CH_W;

  logic [DATA_W-1:0]   hist_q [NSLOT][WIN];
  logic [SUM_W-1:0]    sum_q  [NSLOT];
  logic [AVG_LOG2-1:0] wp_q   [NSLOT];
  logic [NSLOT-1:0]    fill_q;
  logic [CH_W-1:0]     c;
  logic [SUM_W-1:0]    sum_d;

  assign c     = sample_ch_q;
  assign sum_d = sum_q[c] - SUM_W'(hist_q[c][wp_q[c]]) + SUM_W'(sample_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        for (int j = 0; j < WIN; j++) begin
          hist_q[i][j] <= '0;
        end
        sum_q[i] <= '0;
        wp_q[i]  <= '0;
      end
      fill_q       <= '0;
      mean_q       <= '0;
      mean_full_q  <= 1'b0;
      mean_valid_q <= 1'b0;
    end else begin
      mean_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        sum_q[c]           <= sum_d;
        hist_q[c][wp_q[c]] <= sample_q;
        wp_q[c]            <= wp_q[c] + AVG_LOG2'(1);
        // Window is full once the write pointer wraps for the first time.
        if (&wp_q[c]) begin
          fill_q[c] <= 1'b1;
        end
        mean_q      <= sum_d[SUM_W-1:AVG_LOG2];
        mean_full_q <= fill_q[c] | (&wp_q[c]);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      mean_q       <= '0;
      mean_full_q  <= 1'b0;
      mean_valid_q <= 1'b0;
    end else begin
      mean_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        mean_q      <= sample_q;
        mean_full_q <= 1'b1;
      end
    end
  end
`endif

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign ch           = ch_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign mean         = mean_q;
  assign mean_full    = mean_full_q;
  assign mean_valid   = mean_valid_q;

endmodule

// File: doc/adc_serial_avg.md
# adc_serial_avg

Multi-channel successor to the single-channel serial ADC front end. Generates chip-select and serial clock for an external SPI-style converter, deserialises each frame MSB-first, and tags the result with a round-robin channel index. Maintains a per-channel moving average over 2^AVG_LOG2 samples. Sits between the board ADC pins and the vector-control current and voltage measurement path.

## Interface
- DATA_W, 12: converter resolution, in bits.
- LEAD_BITS, 4: leading bits per frame that are clocked in and discarded.
- DIV, 1: sclk half-period, in clk cycles (≥1).
- QUIET, 2: cs_n high time between frames, in clk cycles (≥1).
- NCH, 2: number of channels (1..16).
- AVG_LOG2, 3: log2 of the averaging window (1..6).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; sampled at frame boundaries.
- sdata  in  1  converter serial data.
- cs_n  out  1  converter chip select, active low.
- sclk  out  1  serial clock; idles high.
- ch  out  $clog2(NCH) (min 1)  channel index for the current or next frame; drives the external mux.
- sample  out  DATA_W  last raw conversion.
- sample_ch  out  $clog2(NCH)  channel of `sample`.
- sample_valid  out  1  one-cycle strobe when `sample` updates.
- mean  out  DATA_W  moving average of `sample_ch`.
- mean_full  out  1  window of `sample_ch` holds 2^AVG_LOG2 real samples.
- mean_valid  out  1  one-cycle strobe when `mean` updates.

## Operation
- States and transitions:
  - IDLE → START when en=1.
  - START (DIV cycles) → SHIFT.
  - SHIFT (2·DIV·(LEAD_BITS+DATA_W) cycles) → DONE.
  - DONE (1 cycle) → AVG (1 cycle) → QUIET (QUIET cycles).
  - QUIET → START if en=1, otherwise QUIET → IDLE.
- cs_n is low in START and SHIFT only; high in all other states.
- sclk is high outside SHIFT. In SHIFT, each bit is DIV cycles low followed by DIV cycles high.
- sdata is captured in the clk cycle in which sclk is driven high, i.e. on the sclk rising edge. The first LEAD_BITS bits are dropped; the remaining DATA_W bits are shifted in MSB first.
- DONE: `sample` ← shift register, `sample_ch` ← ch, sample_valid=1.
- AVG: for channel c=sample_ch:
  - sum[c] ← sum[c] − hist[c][wp[c]] + sample
  - hist[c][wp[c]] ← sample
  - wp[c] increments and wraps at 2^AVG_LOG2.
  - mean ← new sum >> AVG_LOG2 (truncating); mean_valid=1.
  - mean_full ← fill[c] after it is updated. fill[c] saturates once wp[c] has wrapped.
- sum width is DATA_W+AVG_LOG2 and cannot overflow.
- QUIET first cycle: ch increments and wraps from NCH−1 to 0. This gives the mux QUIET cycles to settle.
- en=0 mid-frame: the frame completes, including AVG, and the block then goes to IDLE. ch holds its value.

## Timing
- Reset values:
  - cs_n=1, sclk=1, ch=0.
  - sample=0, sample_ch=0, sample_valid=0.
  - mean=0, mean_full=0, mean_valid=0.
  - All hist entries, sums, write pointers and fill flags = 0. State = IDLE.
- rst during any state aborts the frame: cs_n=1 and sclk=1 from the next cycle. No strobe is issued for a partial frame.
- cs_n falls in the cycle after en is seen in IDLE.
- sample_valid fires 1 cycle after the final sclk rising edge; mean_valid fires 1 cycle after sample_valid.
- Frame period = DIV + 2·DIV·(LEAD_BITS+DATA_W) + 2 + QUIET. With default parameters this is 37 clk cycles.
- Outputs are registered; there is no combinational path from sdata or en to any output.

## Configuration
- ADC_AVG_EN defined: history storage and the moving average are built exactly as described above.
- ADC_AVG_EN undefined: no history or sum storage is built.
  - AVG state still exists and mean_valid timing is unchanged.
  - mean ← sample and mean_full ← 1 at every mean_valid.

## Test plan
All scenarios use default parameters and ADC_AVG_EN defined unless stated otherwise.
- Reset: hold rst for 3 cycles with en=1 → all outputs at their reset values, including cs_n=1 and sclk=1. cs_n falls on the 2nd cycle after rst is released.
- Single frame: 4 lead bits, then 0xA5C on ch 0 → sample=0xA5C and sample_ch=0 at sample_valid. One cycle later mean=0x14B and mean_full=0. ch=1 during QUIET.
- Window and wrap (NCH=1): 8 frames of 0x800 → mean=0x800 with mean_full=1 on the 8th. A 9th frame of 0x000 → mean=0x700.
- Round robin (NCH=2): frames of 0x100, 0x200, 0x300 → sample_ch sequence 0,1,0. Means 0x020, 0x040, 0x080. sample_valid strobes are 37 cycles apart.
- Reset mid-SHIFT: assert rst at SHIFT cycle 10 → cs_n=1 the next cycle, no sample_valid or mean_valid, and the histories are cleared. A following frame of 0x400 → mean=0x080.
- ADC_AVG_EN undefined: frame of 0xA5C → mean=0xA5C and mean_full=1, with mean_valid 1 cycle after sample_valid.
